dmem_responder: RTL

Data-memory responder for the MIPS core's data port. It is the slave end of the memwrite/dataadr/writedata interface. It accepts one load or store request at a time and inserts a parameterised number of wait states. It then completes the request with a one-cycle ready pulse, returning read data or an error. It replaces the zero-latency data RAM, so the core can be exercised against a slow memory.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory responder.
//   state_e     : responder FSM encoding (IDLE, WAIT, RESP)
//   fault_e     : request fault classification
//   WORD_W      : data word width
//   fault_check : classifies a byte address as clean, misaligned or out of range
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_RANGE    = 2'd2
    } fault_e;

    // Any address bit above the word index makes the access out of range.
    function automatic fault_e fault_check(input logic [WORD_W-1:0] adr,
                                           input int unsigned       addr_w);
        fault_e code;
        if (adr[1:0] != 2'b00) begin
            code = FAULT_MISALIGN;
        end else if ((adr >> (addr_w + 2)) != '0) begin
            code = FAULT_RANGE;
        end else begin
            code = FAULT_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array -- DEPTH x WORD_W word storage.
//   clk   : rising-edge clock for the write port
//   we    : write enable, commits wdata to mem[waddr] on the clock edge
//   waddr : write word index
//   wdata : write data
//   raddr : read word index (combinational read)
//   rdata : read data
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; clearing a RAM needs a sequencer, and
    // contents are meant to survive a reset of the responder.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder -- slave end of the core's memwrite/dataadr/writedata data
// port. Accepts one load or store at a time, waits WAIT_CYCLES cycles, then
// answers with a one-cycle ready pulse carrying read data or an error flag.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   mem_en      : request strobe, sampled only in IDLE
//   memwrite    : 1 = store, 0 = load
//   dataadr     : byte address
//   writedata   : store data
//   readdata    : load data, valid while ready=1 (0 otherwise)
//   ready       : one-cycle completion pulse
//   err         : fault flag, valid with ready
//   busy        : high from accept until the cycle after ready
//   last_wr_adr, last_wr_data, wr_count : write log, present only when
//                 DMEM_WRITE_LOG_EN is defined
//
// Build option: define DMEM_WRITE_LOG_EN to add the committed-store log.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        err,
    output logic        busy
`ifdef DMEM_WRITE_LOG_EN
    ,
    output logic [31:0] last_wr_adr,
    output logic [31:0] last_wr_data,
    output logic [15:0] wr_count
`endif
);

    state_e            state_q,    state_d;
    logic [3:0]        cnt_q,      cnt_d;
    logic              wr_q,       wr_d;
    logic [WORD_W-1:0] adr_q,      adr_d;
    logic [WORD_W-1:0] wdata_q,    wdata_d;
    logic              ready_q,    ready_d;
    logic              err_q,      err_d;
    logic              busy_q,     busy_d;
    logic [WORD_W-1:0] readdata_q, readdata_d;

    // With WAIT_CYCLES=0 the response is formed in the accept cycle, so the
    // fault check and array read look at the live inputs while IDLE and at
    // the latched request otherwise.
    logic [WORD_W-1:0] cur_adr;
    logic              cur_wr;
    fault_e            cur_fault;
    logic [WORD_W-1:0] rd_data;
    logic              mem_we;

    assign cur_adr   = (state_q == IDLE) ? dataadr  : adr_q;
    assign cur_wr    = (state_q == IDLE) ? memwrite : wr_q;
    assign cur_fault = fault_check(cur_adr, ADDR_W);

    // A store commits on the edge that ends RESP; err_q doubles as the
    // latched fault flag there. Reset during RESP aborts the write.
    assign mem_we = (state_q == RESP) && wr_q && !err_q && !rst;

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (adr_q[ADDR_W+1:2]),
        .wdata (wdata_q),
        .raddr (cur_adr[ADDR_W+1:2]),
        .rdata (rd_data)
    );

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        readdata_d = '0;

        unique case (state_q)
            IDLE: begin
                busy_d = mem_en;
                if (mem_en) begin
                    wr_d    = memwrite;
                    adr_d   = dataadr;
                    wdata_d = writedata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                busy_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Response outputs are registered on the transition into RESP.
        if (state_d == RESP && state_q != RESP) begin
            ready_d = 1'b1;
            err_d   = (cur_fault != FAULT_NONE);
            if (!cur_wr && cur_fault == FAULT_NONE) begin
                readdata_d = rd_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            adr_q      <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign busy     = busy_q;

`ifdef DMEM_WRITE_LOG_EN
    logic [31:0] last_wr_adr_q,  last_wr_adr_d;
    logic [31:0] last_wr_data_q, last_wr_data_d;
    logic [15:0] wr_count_q,     wr_count_d;

    // Log follows exactly the stores that reach the array; the counter
    // wraps naturally at 16 bits.
    always_comb begin
        last_wr_adr_d  = last_wr_adr_q;
        last_wr_data_d = last_wr_data_q;
        wr_count_d     = wr_count_q;
        if (mem_we) begin
            last_wr_adr_d  = adr_q;
            last_wr_data_d = wdata_q;
            wr_count_d     = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_wr_adr_q  <= '0;
            last_wr_data_q <= '0;
            wr_count_q     <= '0;
        end else begin
            last_wr_adr_q  <= last_wr_adr_d;
            last_wr_data_q <= last_wr_data_d;
            wr_count_q     <= wr_count_d;
        end
    end

    assign last_wr_adr  = last_wr_adr_q;
    assign last_wr_data = last_wr_data_q;
    assign wr_count     = wr_count_q;
`endif

endmodule
